// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, FSM encoding and segment table for the 595 digit scanner
//
// Contents:
//   FRAME_BITS   : bits per serial frame (8 segment + 8 digit-select)
//   LATCH_CYC    : slot cycle on which the frame is latched (2 cycles per bit)
//   scan_state_t : SHIFT / LATCH / HOLD slot phases
//   SEG_CODE     : active-low a..g,dp codes for hex 0..F, dp bit shown off

package seg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LATCH_CYC  = 2 * FRAME_BITS;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_LATCH = 2'd1,
    ST_HOLD  = 2'd2
  } scan_state_t;

  // Bit 7..1 = a..g, bit 0 = dp; all active-low.
  localparam logic [7:0] SEG_CODE [16] = '{
    8'b00000011,  // 0
    8'b10011111,  // 1
    8'b00100101,  // 2
    8'b00001101,  // 3
    8'b10011001,  // 4
    8'b01001001,  // 5
    8'b01000001,  // 6
    8'b00011111,  // 7
    8'b00000001,  // 8
    8'b00011001,  // 9
    8'b00010001,  // A
    8'b11000001,  // b
    8'b01100011,  // C
    8'b10000101,  // d
    8'b01100001,  // E
    8'b01110001   // F
  };

endpackage

// File: rtl/seg_hex_dec.sv
// rtl/seg_hex_dec.sv - combinational hex digit to active-low segment byte decoder
//
// Ports:
//   val   : 4-bit hex value
//   dp    : decimal point, 1 = lit
//   blank : 1 = digit dark (all segments off)
//   seg   : active-low segment byte, seg[7..1] = a..g, seg[0] = dp

module seg_hex_dec (
  input  logic [3:0] val,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  import seg_pkg::*;

  always_comb begin
    seg = 8'hFF;
    if (!blank) begin
      seg = {SEG_CODE[val][7:1], ~dp};
    end
  end

endmodule

// File: rtl/seg_scan_serial.sv
// rtl/seg_scan_serial.sv - multiplexed 7-segment scanner driving a 74HC595 chain serially
//
// Optional feature macro: SEG_BLINK_EN (adds blink port, BLINK_SLOTS and blink phase counter).
//
// Parameters:
//   NDIG        : digits scanned (1..8)
//   SLOT_CYC    : clk1mhz cycles per digit slot (>= 40)
//   BLINK_SLOTS : full scans per blink half-period (SEG_BLINK_EN only)
// Ports:
//   clk1mhz   : clock, all flops rising-edge
//   rst       : synchronous active-high reset
//   q         : hex value per digit, digit i at q[4i+3:4i]
//   dp        : decimal point per digit, 1 = lit
//   blank     : 1 = digit dark
//   blink     : 1 = digit blinks (SEG_BLINK_EN only)
//   sclk      : 595 shift clock
//   rclk      : 595 latch clock
//   dio       : 595 serial data
//   scan_done : one-cycle pulse when the last digit's frame is latched

module seg_scan_serial #(
  parameter int NDIG     = 6,
  parameter int SLOT_CYC = 1000
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_SLOTS = 500
`endif
) (
  input  logic              clk1mhz,
  input  logic              rst,
  input  logic [NDIG*4-1:0] q,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blank,
`ifdef SEG_BLINK_EN
  input  logic [NDIG-1:0]   blink,
`endif
  output logic              sclk,
  output logic              rclk,
  output logic              dio,
  output logic              scan_done
);
  import seg_pkg::*;

  localparam int            SW         = $clog2(SLOT_CYC);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYC - 1);
  localparam logic [SW-1:0] SLOT_LATCH = SW'(LATCH_CYC);
  localparam logic [2:0]    DIG_LAST   = 3'(NDIG - 1);

  logic [SW-1:0]         slot_cnt;
  logic [SW-1:0]         slot_nxt;
  logic [2:0]            dig_idx;
  scan_state_t           state;
  scan_state_t           state_nxt;

  logic [NDIG*4-1:0]     snap_q;
  logic [NDIG-1:0]       snap_dp;
  logic [NDIG-1:0]       snap_blank;

  logic                  snap_cycle;
  logic [NDIG*4-1:0]     eff_q;
  logic [NDIG-1:0]       eff_dp;
  logic [NDIG-1:0]       eff_blank;
  logic [31:0]           q32;
  logic [7:0]            dp8;
  logic [7:0]            blank8;
  logic [3:0]            dig_val;
  logic                  dig_dark;
  logic [7:0]            seg;
  logic [7:0]            dig_onehot;
  logic [FRAME_BITS-1:0] frame;

  // The snapshot is registered at the end of slot 0 of digit 0, but that
  // same cycle already shifts bit 0 of digit 0, so it reads the live inputs.
  assign snap_cycle = (slot_cnt == '0) && (dig_idx == '0);
  assign eff_q      = snap_cycle ? q     : snap_q;
  assign eff_dp     = snap_cycle ? dp    : snap_dp;
  assign eff_blank  = snap_cycle ? blank : snap_blank;

  // Widen to the 8-digit maximum so digit selection is width-independent.
  assign q32     = 32'(eff_q);
  assign dp8     = 8'(eff_dp);
  assign blank8  = 8'(eff_blank);
  assign dig_val = q32[{dig_idx, 2'b00} +: 4];

`ifdef SEG_BLINK_EN
  localparam int PW = $clog2(BLINK_SLOTS + 1);

  logic [NDIG-1:0] snap_blink;
  logic [NDIG-1:0] eff_blink;
  logic [7:0]      blink8;
  logic [PW-1:0]   phase_cnt;
  logic            phase_on;

  assign eff_blink = snap_cycle ? blink : snap_blink;
  assign blink8    = 8'(eff_blink);
  assign dig_dark  = blank8[dig_idx] | (blink8[dig_idx] & ~phase_on);

  // Phase flips on the scan_done of the last scan of each half-period, so
  // every scan is displayed entirely in one phase.
  always_ff @(posedge clk1mhz) begin
    if (rst) begin
      snap_blink <= '0;
      phase_cnt  <= '0;
      phase_on   <= 1'b1;
    end else begin
      if (snap_cycle) begin
        snap_blink <= blink;
      end
      if (scan_done) begin
        if (phase_cnt == PW'(BLINK_SLOTS - 1)) begin
          phase_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          phase_cnt <= phase_cnt + PW'(1);
        end
      end
    end
  end
`else
  assign dig_dark = blank8[dig_idx];
`endif

  seg_hex_dec u_dec (
    .val   (dig_val),
    .dp    (dp8[dig_idx]),
    .blank (dig_dark),
    .seg   (seg)
  );

  // dig_idx never exceeds NDIG-1, so bits >= NDIG stay 0.
  assign dig_onehot = 8'b1 << dig_idx;

  // frame[k] is the k-th bit shifted: seg[0..7], then dig[7..0].
  always_comb begin
    frame[7:0] = seg;
    for (int j = 0; j < 8; j++) begin
      frame[8 + j] = dig_onehot[7 - j];
    end
  end

  assign slot_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SW'(1);

  always_ff @(posedge clk1mhz) begin
    if (rst) begin
      slot_cnt   <= '0;
      dig_idx    <= '0;
      state      <= ST_SHIFT;
      snap_q     <= '0;
      snap_dp    <= '0;
      snap_blank <= '1;
    end else begin
      slot_cnt <= slot_nxt;
      state    <= state_nxt;
      if (slot_cnt == SLOT_LAST) begin
        dig_idx <= (dig_idx == DIG_LAST) ? 3'd0 : dig_idx + 3'd1;
      end
      if (snap_cycle) begin
        snap_q     <= q;
        snap_dp    <= dp;
        snap_blank <= blank;
      end
    end
  end

  // Outputs are forced low while rst is high: the state register already sits
  // at SHIFT/slot 0 during reset, and a reset mid-frame must never reach LATCH.
  always_comb begin
    state_nxt = ST_HOLD;
    if (slot_nxt < SLOT_LATCH) begin
      state_nxt = ST_SHIFT;
    end else if (slot_nxt == SLOT_LATCH) begin
      state_nxt = ST_LATCH;
    end

    sclk      = 1'b0;
    rclk      = 1'b0;
    dio       = 1'b0;
    scan_done = 1'b0;
    if (!rst) begin
      case (state)
        ST_SHIFT: begin
          sclk = slot_cnt[0];
          dio  = frame[slot_cnt[4:1]];
        end
        ST_LATCH: begin
          rclk      = 1'b1;
          scan_done = (dig_idx == DIG_LAST);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
